// File: rtl/fft_pkg.sv
// Shared constants, sample record and bit-reversal helper for the 512-point FFT
// core and its unloader.
package fft_pkg;

    localparam int N      = 512;
    localparam int LOG2N  = 9;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        logic [LOG2N-1:0]         index;
    } sample_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } unload_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_fifo.sv
// Small register FIFO of sample records; head entry is presented combinationally.
module fft_sample_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  sample_t       push_data,
    input  logic          pop,
    output sample_t       pop_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sample_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entries are cleared on reset so an idle output bus reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/fft_512_unloader.sv
// Reads the FFT core's bit-reversed result RAM and streams the bins out in
// natural order over a valid/ready interface.
module fft_512_unloader
    import fft_pkg::*;
#(
    parameter int OUT_SHIFT = 0,
    parameter int BUF_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr,
    input  logic signed [DATA_W-1:0] rd_re,
    input  logic signed [DATA_W-1:0] rd_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overlap
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    unload_state_t    state, next_state;
    logic [LOG2N-1:0] k;
    logic [LOG2N-1:0] k_d;
    logic             inflight;
    logic             start_q;
    logic             start_edge;
    logic             credit_ok;
    logic             pop;
    sample_t          push_data;
    sample_t          head;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    assign start_edge = start & ~start_q;
    // A read may issue only if its data is guaranteed a buffer slot on return.
    assign credit_ok  = !full && ((int'(count) + int'(inflight)) < BUF_DEPTH);

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_edge) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (k == LOG2N'(N - 1)) next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && empty) begin
                    done       = 1'b1;
                    busy       = 1'b0;
                    next_state = start_edge ? S_ISSUE : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
        err_overlap = start_edge && busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            k        <= '0;
            k_d      <= '0;
            inflight <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state    <= next_state;
            start_q  <= start;
            inflight <= rd_en;
            if (rd_en) k_d <= k;
            if (state != S_ISSUE && next_state == S_ISSUE) begin
                k <= '0;
            end else if (rd_en) begin
                k <= k + 1'b1;
            end
        end
    end

    assign rd_addr = bitrev(k);

    always_comb begin
        push_data       = '0;
        push_data.re    = rd_re >>> OUT_SHIFT;
        push_data.im    = rd_im >>> OUT_SHIFT;
        push_data.index = k_d;
    end

    fft_sample_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_re    = head.re;
    assign out_im    = head.im;
    assign out_index = head.index;
    assign out_last  = out_valid && (head.index == LOG2N'(N - 1));

endmodule

// File: tb/tb_fft_512_unloader.sv
// Scoreboard bench: two unloaders (shift 0 and shift 2) read the same RAM model
// and are checked against expected natural-order bin sequences.
module tb_fft_512_unloader;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    logic                     rd_en0, rd_en2;
    logic [LOG2N-1:0]         rd_addr0, rd_addr2;
    logic signed [DATA_W-1:0] rd_re0, rd_im0, rd_re2, rd_im2;
    logic                     out_valid0, out_valid2;
    logic signed [DATA_W-1:0] out_re0, out_im0, out_re2, out_im2;
    logic [LOG2N-1:0]         out_index0, out_index2;
    logic                     out_last0, out_last2;
    logic                     busy0, busy2, done0, done2, err0, err2;

    always #5 clk = ~clk;

    fft_512_unloader #(.OUT_SHIFT(0), .BUF_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_re(rd_re0), .rd_im(rd_im0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_re(out_re0), .out_im(out_im0), .out_index(out_index0), .out_last(out_last0),
        .busy(busy0), .done(done0), .err_overlap(err0)
    );

    fft_512_unloader #(.OUT_SHIFT(2), .BUF_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_re(rd_re2), .rd_im(rd_im2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_re(out_re2), .out_im(out_im2), .out_index(out_index2), .out_last(out_last2),
        .busy(busy2), .done(done2), .err_overlap(err2)
    );

    // Core result RAM model with a one-cycle synchronous read.
    logic signed [DATA_W-1:0] ram_re [N];
    logic signed [DATA_W-1:0] ram_im [N];

    always @(posedge clk) begin
        if (rd_en0) begin
            rd_re0 <= ram_re[rd_addr0];
            rd_im0 <= ram_im[rd_addr0];
        end
        if (rd_en2) begin
            rd_re2 <= ram_re[rd_addr2];
            rd_im2 <= ram_im[rd_addr2];
        end
    end

    typedef struct { int k; int re; int im; } exp_t;
    exp_t q0[$];
    exp_t q2[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int beats0 = 0, first_cyc = 0, last_cyc = -10;
    int done_cnt0 = 0, done_cnt2 = 0, err_cnt0 = 0, err_cnt2 = 0;
    bit rand_ready = 0, ready_zero = 0;
    bit stall [2];
    logic signed [DATA_W-1:0] sre [2];
    logic signed [DATA_W-1:0] sim [2];
    logic [LOG2N-1:0] sidx [2];
    int outst [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ck(input bit ok, input string name, input int act, input int want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic int tb_rev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (((k >> i) & 1) != 0) r += 1 << (LOG2N - 1 - i);
        end
        return r;
    endfunction

    // Expected stream for one unload: natural bin k holds RAM[bitrev(k)].
    task automatic launch();
        exp_t e;
        beats0 = 0;
        for (int k = 0; k < N; k++) begin
            e.k  = k;
            e.re = int'(ram_re[tb_rev(k)]);
            e.im = int'(ram_im[tb_rev(k)]);
            q0.push_back(e);
            q2.push_back(e);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic signed [DATA_W-1:0] re,
                            input logic signed [DATA_W-1:0] im, input logic [LOG2N-1:0] idx,
                            input logic last, input logic ren);
        exp_t e;
        int sh;
        bit have;
        sh = 2 * p;
        if (stall[p]) begin
            ck(v && re == sre[p] && im == sim[p] && idx == sidx[p],
               $sformatf("stable_p%0d", p), int'(idx), int'(sidx[p]));
        end
        if (ren) ck(outst[p] < 4, $sformatf("credit_p%0d", p), outst[p], 3);
        if (v && out_ready) begin
            have = 0;
            if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            if (p == 1 && q2.size() > 0) begin e = q2.pop_front(); have = 1; end
            if (!have) begin
                ck(0, $sformatf("extra_beat_p%0d", p), int'(idx), -1);
            end else begin
                ck(int'(idx) == e.k, $sformatf("index_p%0d", p), int'(idx), e.k);
                ck(int'(re) == (e.re >>> sh), $sformatf("re_p%0d_k%0d", p, e.k), int'(re), e.re >>> sh);
                ck(int'(im) == (e.im >>> sh), $sformatf("im_p%0d_k%0d", p, e.k), int'(im), e.im >>> sh);
                ck(last == (e.k == N - 1), $sformatf("last_p%0d_k%0d", p, e.k), int'(last), int'(e.k == N - 1));
            end
        end
        outst[p] += int'(ren) - int'(v && out_ready);
        stall[p] = v && !out_ready;
        sre[p] = re;
        sim[p] = im;
        sidx[p] = idx;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q2.delete();
            stall = '{0, 0};
            outst = '{0, 0};
            beats0 = 0;
        end else begin
            mon_port(0, out_valid0, out_re0, out_im0, out_index0, out_last0, rd_en0);
            mon_port(1, out_valid2, out_re2, out_im2, out_index2, out_last2, rd_en2);
            if (out_valid0 && out_ready) begin
                if (out_index0 == 0) first_cyc = cyc;
                if (out_last0) last_cyc = cyc;
                beats0++;
            end
            if (done0) begin
                done_cnt0++;
                ck(cyc == last_cyc + 1, "done_timing", cyc, last_cyc + 1);
            end
            if (done2) done_cnt2++;
            if (err0) err_cnt0++;
            if (err2) err_cnt2++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_zero ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 6000 && done_cnt0 < target; i++) step();
        ck(done_cnt0 >= target, "done_wait", done_cnt0, target);
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 6000 && beats0 < target; i++) step();
        ck(beats0 >= target, "beat_wait", beats0, target);
    endtask

    task automatic fill_random();
        for (int a = 0; a < N; a++) begin
            ram_re[a] = DATA_W'($urandom);
            ram_im[a] = DATA_W'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        ck(rd_en0 == 0 && rd_addr0 == 0, "rst_read_port", int'(rd_addr0), 0);
        ck(out_valid0 == 0 && out_last0 == 0, "rst_valid_last", int'(out_valid0), 0);
        ck(out_re0 == 0 && out_im0 == 0 && out_index0 == 0, "rst_data", int'(out_re0), 0);
        ck(busy0 == 0 && done0 == 0 && err0 == 0, "rst_status", int'(busy0), 0);
        step();
        reset = 0;
        for (int a = 0; a < N; a++) begin
            ram_re[a] = DATA_W'(a);
            ram_im[a] = DATA_W'(-a);
        end
        repeat (2) step();

        // Ramp RAM, ready held high: latency, order, throughput
        launch();
        start = 1;
        @(negedge clk);
        ck(rd_en0 == 0, "lat_rd_en_T", int'(rd_en0), 0);
        @(negedge clk);
        ck(rd_en0 == 1 && rd_addr0 == 0 && busy0 == 1, "lat_rd_en_T1", int'(rd_en0), 1);
        @(negedge clk);
        ck(rd_en0 == 1 && rd_addr0 == 256, "bitrev_k1", int'(rd_addr0), 256);
        ck(out_valid0 == 0, "lat_valid_T2", int'(out_valid0), 0);
        @(negedge clk);
        ck(out_valid0 == 1, "lat_valid_T3", int'(out_valid0), 1);
        wait_done(1);
        repeat (5) step();
        ck(done_cnt0 == 1, "done_count_1", done_cnt0, 1);
        ck(beats0 == N, "beats_1", beats0, N);
        ck(last_cyc - first_cyc == N - 1, "throughput", last_cyc - first_cyc, N - 1);

        // Random data, random ready, shift corners, overlapping start edge
        start = 0;
        fill_random();
        ram_re[0] = -16'sd32768;
        ram_re[256] = 16'sd7;
        step();
        launch();
        start = 1;
        rand_ready = 1;
        repeat (5) step();
        start = 0;
        wait_beats(100);
        start = 1;
        wait_done(2);
        repeat (5) step();
        ck(done_cnt0 == 2, "done_count_2", done_cnt0, 2);
        ck(err_cnt0 == 1, "err_overlap_count", err_cnt0, 1);
        ck(beats0 == N, "beats_2", beats0, N);

        // Reset mid-stream; start held high restarts from k=0 after release
        start = 0;
        fill_random();
        step();
        launch();
        start = 1;
        wait_beats(300);
        ready_zero = 1;
        reset = 1;
        step();
        reset = 0;
        ready_zero = 0;
        launch();
        @(negedge clk);
        ck(out_valid0 == 0 && busy0 == 0, "abort_outputs", int'(out_valid0) + int'(busy0), 0);
        ck(done_cnt0 == 2, "abort_no_done", done_cnt0, 2);
        wait_done(3);
        repeat (2000) step();
        ck(done_cnt0 == 3, "hold_no_retrigger", done_cnt0, 3);
        ck(busy0 == 0, "hold_idle", int'(busy0), 0);

        ck(q0.size() == 0, "q0_drained", q0.size(), 0);
        ck(q2.size() == 0, "q2_drained", q2.size(), 0);
        ck(done_cnt2 == done_cnt0, "done_shift2", done_cnt2, done_cnt0);
        ck(err_cnt2 == err_cnt0, "err_shift2", err_cnt2, err_cnt0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_512_unloader.md
Name: fft_512_unloader

Overview:
- Downstream stage of the 512-point iterative FFT core. The core computes in place with decimation in frequency, so its RAM holds results in bit-reversed order.
- On the core's completion, this block reads the core's result RAM through a synchronous read port and reorders the data into natural frequency order.
- Output is a valid/ready sample stream with a bin index and a last flag, feeding the SoC's result sink (DMA/magnitude stage).

Parameters:
- N, 512: FFT length; must be a power of two.
- LOG2N, 9: address and index width.
- DATA_W, 16: signed Q15 width of re and im.
- OUT_SHIFT, 0: arithmetic right shift applied to the output samples; valid range 0..8.
- BUF_DEPTH, 4: output buffer entries; must be ≥3 for full throughput.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  driven from the FFT core's done, which is a level; a rising edge triggers unloading.
- rd_en  out  1  read request to the core RAM.
- rd_addr  out  LOG2N  core RAM read address.
- rd_re  in  DATA_W  signed; valid the cycle after rd_en.
- rd_im  in  DATA_W  signed; valid the cycle after rd_en.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_re  out  DATA_W  signed, shifted real part.
- out_im  out  DATA_W  signed, shifted imaginary part.
- out_index  out  LOG2N  natural-order bin k.
- out_last  out  1  high with bin N-1.
- busy  out  1  high while unloading.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err_overlap  out  1  one-cycle pulse when a start edge arrives while busy.

Behaviour:
- Reset:
  - All outputs are 0, including rd_addr, out_*, busy, done and err_overlap.
  - Buffer is flushed, state is IDLE, k=0.
  - The start edge detector's previous-value register is cleared to 0. A start already high at reset release therefore counts as a rising edge.
- Reset mid-operation: unloading aborts immediately, with no done pulse. Outputs take their reset values the following cycle.
- FSM states:
  - IDLE: on a start rising edge → ISSUE, busy=1, k=0.
  - ISSUE: issue reads for k=0..N-1. After issuing k=N-1 → DRAIN.
  - DRAIN: wait until the in-flight read and the buffer are empty and the last beat has been accepted. Then → IDLE, with done=1 for one cycle and busy=0 the same cycle.
- Read rule:
  - rd_addr = bit-reverse of k over LOG2N bits. Examples: k=1 → 256, k=2 → 128, k=511 → 511.
  - rd_en is asserted in cycle C only when (buffer occupancy + in-flight reads) < BUF_DEPTH. k increments on each issued read.
  - rd_addr is don't-care when rd_en=0.
- Pipeline timing: rd_en in cycle C → rd_re/rd_im sampled at the end of C+1 into the buffer → out_valid is asserted in C+2 at the earliest.
- Start-to-output latency: a start edge sampled in cycle T gives the first rd_en in T+1 and the first out_valid in T+3.
- Throughput: with out_ready held at 1, all N beats appear in N consecutive cycles.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_re, out_im, out_index and out_last stay stable.
  - out_valid never drops without a transfer.
  - The buffer never overflows; backpressure stops rd_en.
- Simultaneous push and pop in the same cycle is allowed and leaves occupancy unchanged.
- Arithmetic:
  - out_re = rd_re >>> OUT_SHIFT, sign-extended; out_im is the same on rd_im.
  - No rounding; truncation toward −∞.
- out_index carries the k travelling with each sample. out_last = (out_index == N-1).
- Start edge while busy: ignored, and err_overlap pulses. The stream in progress is unaffected.
- Start held high after done: no retrigger. A low phase is required before the next edge.

Decomposition:
- Package fft_pkg holds:
  - the constants N, LOG2N and DATA_W;
  - a sample record/struct {re, im, index};
  - a bitrev(k) function shared with the core's testbench.
- One natural sub-module, fft_sample_fifo: a parameterised BUF_DEPTH register FIFO with push/pop, count, empty and full, and its own synchronous reset.

Test Plan:
- Preload RAM[a]=a (re) and −a (im), start edge, out_ready=1:
  - 512 consecutive beats;
  - beat k has out_re=bitrev(k) and out_im=−bitrev(k); e.g. k=1 → re=256, im=−256;
  - out_last only on k=511;
  - done pulses one cycle after that beat;
  - first out_valid 3 cycles after the edge.
- Random out_ready (50%):
  - data order and values match the reference sequence;
  - outputs stay stable while stalled;
  - rd_en never issues with occupancy+in-flight ≥4;
  - no beat is lost or duplicated.
- OUT_SHIFT=2 with RAM[0]=−32768 and RAM[256]=7:
  - bin 0 gives out_re=−8192;
  - bin 1 gives out_re=1.
- Second start edge at beat 100: err_overlap pulses once, all 512 beats still delivered, exactly one done pulse.
- Reset asserted at beat 300:
  - next cycle out_valid=0 and busy=0;
  - no done pulse;
  - a fresh start edge streams from k=0 correctly.
- start held high for 2000 cycles after completion: exactly one unload and one done.
